// File: rtl/sudoku_wb_pkg.sv
// rtl/sudoku_wb_pkg.sv - shared types and constants for the sudoku accelerator Wishbone initiator
package sudoku_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam int DEFAULT_ADR_W = 32;
  localparam int DEFAULT_DAT_W = 32;

  // Accelerator register map as seen by the self-test sequencer (byte offsets)
  localparam logic [31:0] SUDOKU_REG_CTRL      = 32'h0000_0000;
  localparam logic [31:0] SUDOKU_REG_STATUS    = 32'h0000_0004;
  localparam logic [31:0] SUDOKU_REG_CYCLES    = 32'h0000_0010;
  localparam logic [31:0] SUDOKU_REG_GRID_BASE = 32'h0000_0100;
  localparam logic [31:0] SUDOKU_REG_SOLN_BASE = 32'h0000_0200;

endpackage

// File: rtl/sudoku_wb_master.sv
// rtl/sudoku_wb_master.sv - single-request Wishbone classic initiator with stb timeout
module sudoku_wb_master
  import sudoku_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADR_W          = DEFAULT_ADR_W,
  parameter int DAT_W          = DEFAULT_DAT_W
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADR_W-1:0]   req_adr,
  input  logic [DAT_W-1:0]   req_dat,
  input  logic [DAT_W/8-1:0] req_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DAT_W-1:0]   rsp_dat,
  output logic               rsp_err,
  output logic               busy,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [ADR_W-1:0]   wb_adr_o,
  output logic [DAT_W-1:0]   wb_dat_o,
  output logic [DAT_W/8-1:0] wb_sel_o,
  input  logic               wb_ack_i,
  input  logic [DAT_W-1:0]   wb_dat_i
);

  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W  = TMO_EN ? (($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  wb_state_e        state;
  wb_state_e        state_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             accept;
  logic             ack_hit;
  logic             timeout_hit;
  logic             rsp_fire;

  assign accept      = (state == ST_IDLE) && req_valid;
  assign ack_hit     = (state == ST_BUS) && wb_ack_i;
  // Ack sampled on the expiry cycle takes priority over the abort
  assign timeout_hit = TMO_EN && (state == ST_BUS) && !wb_ack_i && (tmo_cnt == CNT_LAST);
  assign rsp_fire    = (state == ST_RESP) && rsp_ready;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_BUS;
      ST_BUS:  if (ack_hit || timeout_hit) state_nxt = ST_RESP;
      ST_RESP: if (rsp_fire) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      if (accept) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= req_we;
        wb_adr_o <= req_adr;
        wb_dat_o <= req_dat;
        wb_sel_o <= req_sel;
        tmo_cnt  <= '0;
      end
      if (state == ST_BUS) begin
        if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
        if (ack_hit || timeout_hit) begin
          wb_cyc_o  <= 1'b0;
          wb_stb_o  <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= timeout_hit;
          rsp_dat   <= (ack_hit && !wb_we_o) ? wb_dat_i : '0;
        end
      end
      if (rsp_fire) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sudoku_wb_master.sv
// tb/tb_sudoku_wb_master.sv - randomized self-checking bench for sudoku_wb_master
module tb_sudoku_wb_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  sudoku_wb_master #(.TIMEOUT_CYCLES(TMO), .ADR_W(32), .DAT_W(32)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .busy(busy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ack_at: stb cycle index (0-based) on which the slave acks; >= TMO means never
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_at, input logic [31:0] rd,
                         input int hold);
    int          t0;
    int          n;
    int          exp_stb;
    logic        exp_err;
    logic [31:0] exp_dat;
    exp_err = (ack_at >= TMO);
    exp_stb = exp_err ? TMO : ack_at + 1;
    exp_dat = (we || exp_err) ? 32'h0 : rd;

    check("req_ready_idle", req_ready, 1);
    check("busy_idle", busy, 0);
    t0 = cyc_cnt;
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    tick();
    req_valid = 1'b0; req_adr = $urandom; req_dat = $urandom; req_sel = 4'($urandom); req_we = ~we;

    n = 0;
    while (wb_stb_o && n < 4 * TMO) begin
      check("bus_cyc", wb_cyc_o, 1);
      check("bus_we", wb_we_o, we);
      check("bus_adr", wb_adr_o, adr);
      check("bus_dat", wb_dat_o, dat);
      check("bus_sel", wb_sel_o, sel);
      check("bus_req_ready", req_ready, 0);
      wb_ack_i = (n == ack_at);
      wb_dat_i = (n == ack_at) ? rd : $urandom;
      tick();
      n++;
    end
    wb_ack_i = 1'b0;
    check("stb_cycles", n, exp_stb);
    check("cyc_dropped", wb_cyc_o, 0);

    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      wb_ack_i  = 1'($urandom);
      wb_dat_i  = $urandom;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_dat", rsp_dat, exp_dat);
      check("hold_rsp_err", rsp_err, exp_err);
      check("hold_req_ready", req_ready, 0);
      tick();
    end
    wb_ack_i = 1'b0;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_dat", rsp_dat, exp_dat);
    check("rsp_err", rsp_err, exp_err);
    rsp_ready = 1'b1;
    req_valid = (hold > 0);
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("rsp_cleared", rsp_valid, 0);
    check("req_ready_back", req_ready, 1);
    check("no_passthrough_cyc", wb_cyc_o, 0);
    check("txn_cycles", cyc_cnt - t0, exp_stb + 2 + hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
    rsp_ready = 1'b0; wb_ack_i = 1'b0; wb_dat_i = '0;
    @(negedge clk);
    tick();
    tick();
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    rst = 1'b0;
    tick();

    run_txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 32'h1234_5678, 0);
    run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 0, 32'h0000_01FF, 0);
    run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 99, 32'hCAFE_0001, 0);
    run_txn(1'b0, 32'h3000_0024, 32'h0, 4'h3, TMO - 1, 32'hA5A5_5A5A, 0);
    run_txn(1'b0, 32'h3000_0028, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 5);

    // Reset during the second stb cycle discards the transaction
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0030; req_sel = 4'hF;
    tick();
    req_valid = 1'b0;
    check("rstmid_stb1", wb_stb_o, 1);
    tick();
    check("rstmid_stb2", wb_stb_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_cyc", wb_cyc_o, 0);
    check("rstmid_stb", wb_stb_o, 0);
    check("rstmid_rsp_valid", rsp_valid, 0);
    check("rstmid_req_ready", req_ready, 1);
    wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stray_ack_rsp", rsp_valid, 0);
      check("stray_ack_busy", busy, 0);
    end
    wb_ack_i = 1'b0;

    for (int t = 0; t < 30; t++) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
        wb_ack_i = 1'($urandom);
        tick();
        check("idle_rsp_valid", rsp_valid, 0);
      end
      wb_ack_i = 1'b0;
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
              $urandom_range(0, TMO + 2), $urandom, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
